iddr_deserialize_and_align: RTL and testbench

- Receive-side counterpart of the ODDR half-rate serializer path.
- Samples a single-ended serial line on both edges of clk_i (IDDR style): two bits per clk_i cycle.
- Deserializes the bits into WIDTH_P-bit words and finds word alignment by hunting for a sync pattern, at either bit offset.
- Once locked, delivers words through a 2-entry valid/ready buffer to core logic in the clk_i domain.

---
 rtl/iddr_deserialize_and_align_pkg.sv | 19 +
 rtl/iddr_deserialize_and_align_if.sv | 13 +
 rtl/iddr_deserialize_and_align_fifo.sv | 65 ++++++
 rtl/iddr_deserialize_and_align.sv | 156 +++++++++++++++
 tb/tb_iddr_deserialize_and_align.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/iddr_deserialize_and_align_pkg.sv
// Shared types and defaults for the IDDR receive-side deserializer and word aligner.
package iddr_align_pkg;

    localparam int                       DEFAULT_WIDTH = 8;
    localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_SYNC  = 8'hBC;

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } align_state_e;

    // Buffered word at the default width: received bits plus "this is the sync pattern" flag.
    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] data;
        logic                     sync;
    } rx_word_s;

endpackage

// File: rtl/iddr_deserialize_and_align_if.sv
// Valid/ready stream carrying one flat payload; master drives payload/valid, slave drives ready.
interface iddr_deserialize_and_align_if #(
    parameter int W = 9
) ();

    logic [W-1:0] payload;
    logic         valid;
    logic         ready;

    modport master (output payload, output valid, input ready);
    modport slave  (input payload, input valid, output ready);

endinterface

// File: rtl/iddr_deserialize_and_align_fifo.sv
// Two-entry valid/ready FIFO with synchronous flush; accepts a push on a full buffer when a pop
// happens in the same cycle.
module rx_fifo_2entry #(
    parameter int W = 9
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic                                flush_i,
    iddr_deserialize_and_align_if.slave         push_s,
    iddr_deserialize_and_align_if.master        pop_m
);

    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic [1:0]   count_q, count_d;
    logic [1:0]   keep_cnt;
    logic         push;
    logic         pop;

    assign pop_m.valid   = (count_q != 2'd0);
    assign pop_m.payload = slot0_q;
    assign push_s.ready  = (count_q != 2'd2) || pop_m.ready;

    assign pop      = pop_m.valid && pop_m.ready;
    assign push     = push_s.valid && push_s.ready;
    assign keep_cnt = count_q - {1'b0, pop};

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                slot0_d = slot1_q;
            end
            if (push) begin
                if (keep_cnt == 2'd0) begin
                    slot0_d = push_s.payload;
                end else begin
                    slot1_d = push_s.payload;
                end
            end
            count_d = keep_cnt + {1'b0, push};
        end
    end

    // NOTE: the storage slots are reset as well, so the head payload reads zero straight out of
    // reset instead of stale contents.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/iddr_deserialize_and_align.sv
// IDDR capture of a serial line, word alignment by sync-pattern hunting at either bit offset,
// and delivery of locked words through a two-entry valid/ready buffer.
module iddr_deserialize_and_align
    import iddr_align_pkg::*;
#(
    parameter int                 WIDTH_P        = 8,
    parameter logic [WIDTH_P-1:0] SYNC_PATTERN_P = WIDTH_P'(DEFAULT_SYNC),
    parameter int                 LOCK_COUNT_P   = 3
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               data_i,
    input  logic               resync_i,
    output logic [WIDTH_P-1:0] data_o,
    output logic               sync_o,
    output logic               v_o,
    input  logic               ready_i,
    output logic               locked_o,
    output logic               overflow_o
);

    localparam int                 PAIRS     = WIDTH_P / 2;
    localparam int                 PCW       = $clog2(PAIRS);
    localparam int                 MCW       = $clog2(LOCK_COUNT_P + 1);
    localparam logic [PCW-1:0]     LAST_PAIR = PCW'(PAIRS - 1);
    localparam logic [MCW-1:0]     LOCK_CNT  = MCW'(LOCK_COUNT_P);

    typedef struct packed {
        logic [WIDTH_P-1:0] data;
        logic               sync;
    } word_t;

    logic               neg_q;
    logic [WIDTH_P:0]   hist_q;
    align_state_e       state_q, state_d;
    logic               off_q, off_d;
    logic [PCW-1:0]     pair_cnt_q, pair_cnt_d;
    logic [MCW-1:0]     match_cnt_q, match_cnt_d;
    logic               overflow_q, overflow_d;
    logic               push_valid;

    logic [WIDTH_P-1:0] win0, win1, word;
    logic               boundary;
    logic               word_is_sync;
    word_t              push_word, head;

    iddr_deserialize_and_align_if #(.W(WIDTH_P + 1)) fifo_in  ();
    iddr_deserialize_and_align_if #(.W(WIDTH_P + 1)) fifo_out ();

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(negedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) neg_q <= 1'b0;
        else            neg_q <= data_i;
    end

    // The falling-edge bit is the older of each pair, so it lands above the rising-edge bit.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) hist_q <= '0;
        else            hist_q <= {hist_q[WIDTH_P-2:0], neg_q, data_i};
    end

    assign win0         = hist_q[WIDTH_P-1:0];
    assign win1         = hist_q[WIDTH_P:1];
    assign word         = off_q ? win1 : win0;
    assign word_is_sync = (word == SYNC_PATTERN_P);
    assign boundary     = (state_q != HUNT) && (pair_cnt_q == LAST_PAIR);

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        pair_cnt_d  = pair_cnt_q;
        match_cnt_d = match_cnt_q;
        overflow_d  = overflow_q;
        push_valid  = 1'b0;

        if (state_q != HUNT) begin
            pair_cnt_d = boundary ? '0 : pair_cnt_q + 1'b1;
        end

        unique case (state_q)
            HUNT: begin
                if ((win0 == SYNC_PATTERN_P) || (win1 == SYNC_PATTERN_P)) begin
                    off_d       = (win0 != SYNC_PATTERN_P);
                    pair_cnt_d  = '0;
                    match_cnt_d = MCW'(1);
                    state_d     = (LOCK_COUNT_P == 1) ? LOCKED : CHECK;
                end
            end
            CHECK: begin
                if (boundary) begin
                    if (word_is_sync) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                        if ((match_cnt_q + 1'b1) == LOCK_CNT) state_d = LOCKED;
                    end else begin
                        state_d     = HUNT;
                        pair_cnt_d  = '0;
                        match_cnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    push_valid = 1'b1;
                    if (!fifo_in.ready) overflow_d = 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase

        // Resync overrides everything, including a push due in this same cycle.
        if (resync_i) begin
            state_d     = HUNT;
            pair_cnt_d  = '0;
            match_cnt_d = '0;
            overflow_d  = 1'b0;
            push_valid  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= HUNT;
            off_q       <= 1'b0;
            pair_cnt_q  <= '0;
            match_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            pair_cnt_q  <= pair_cnt_d;
            match_cnt_q <= match_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    assign push_word       = '{data: word, sync: word_is_sync};
    assign fifo_in.payload = push_word;
    assign fifo_in.valid   = push_valid;
    assign fifo_out.ready  = ready_i;

    rx_fifo_2entry #(.W(WIDTH_P + 1)) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flush_i   (resync_i),
        .push_s    (fifo_in),
        .pop_m     (fifo_out)
    );

    assign head       = word_t'(fifo_out.payload);
    assign data_o     = head.data;
    assign sync_o     = head.sync;
    assign v_o        = fifo_out.valid;
    assign locked_o   = (state_q == LOCKED);
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_iddr_deserialize_and_align.sv
// Directed bench for the IDDR deserializer/aligner: alignment at both offsets, broken partial
// lock, backpressure and overflow, resync and asynchronous reset.
module tb_iddr_deserialize_and_align;
    import iddr_align_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       data_i;
    logic       resync_i;
    logic       ready_i;
    logic [7:0] data_o;
    logic       sync_o;
    logic       v_o;
    logic       locked_o;
    logic       overflow_o;

    int         checks = 0;
    int         errors = 0;
    rx_word_s   got[$];
    logic       v_seen;
    logic       bitq[$];

    always #5 clk = ~clk;

    iddr_deserialize_and_align #(
        .WIDTH_P        (8),
        .SYNC_PATTERN_P (8'hBC),
        .LOCK_COUNT_P   (3)
    ) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .data_i     (data_i),
        .resync_i   (resync_i),
        .data_o     (data_o),
        .sync_o     (sync_o),
        .v_o        (v_o),
        .ready_i    (ready_i),
        .locked_o   (locked_o),
        .overflow_o (overflow_o)
    );

    iddr_deserialize_and_align_if #(.W(9)) mon_if ();
    assign mon_if.payload = {data_o, sync_o};
    assign mon_if.valid   = v_o;
    assign mon_if.ready   = ready_i;

    // Record every accepted word at the falling edge, away from the rising edge that pops it.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mon_if.valid) v_seen = 1'b1;
            if (mon_if.valid && mon_if.ready) got.push_back(rx_word_s'(mon_if.payload));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] got_w(input int i);
        if (i < got.size()) return 32'(got[i]);
        return 'x;
    endfunction

    function automatic logic [31:0] exp_w(input logic [7:0] d, input logic s);
        return 32'({d, s});
    endfunction

    // One clk cycle: older bit ahead of the falling edge, newer bit ahead of the rising edge.
    task automatic send_pair(input logic b_old, input logic b_new, input logic rdy, input logic rsy);
        @(posedge clk);
        #2;
        data_i   = b_old;
        ready_i  = rdy;
        resync_i = rsy;
        @(negedge clk);
        #2;
        data_i = b_new;
    endtask

    task automatic send_word(input logic [7:0] w, input logic [3:0] rdy = 4'hF,
                             input logic [3:0] rsy = 4'h0);
        for (int i = 0; i < 4; i++) begin
            send_pair(w[7-2*i], w[6-2*i], rdy[3-i], rsy[3-i]);
        end
    endtask

    task automatic add_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) bitq.push_back(w[i]);
    endtask

    task automatic send_bits();
        logic b0, b1;
        while (bitq.size() >= 2) begin
            b0 = bitq.pop_front();
            b1 = bitq.pop_front();
            send_pair(b0, b1, 1'b1, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        data_i   = 1'b0;
        ready_i  = 1'b1;
        resync_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        got.delete();
        v_seen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        reset_n  = 1'b0;
        data_i   = 1'b0;
        ready_i  = 1'b1;
        resync_i = 1'b0;
        v_seen   = 1'b0;
        #3;
        check("reset_outputs", 32'({data_o, sync_o, v_o, locked_o, overflow_o}), 32'd0);

        // Aligned stream at offset 0
        do_reset();
        send_word(8'hBC); send_word(8'hBC); send_word(8'hBC);
        check("s1_not_locked_yet", 32'(locked_o), 32'd0);
        check("s1_no_valid_yet", 32'(v_o), 32'd0);
        send_word(8'hBC);
        check("s1_locked", 32'(locked_o), 32'd1);
        send_word(8'h5A); send_word(8'hC3);
        idle(12);
        check("s1_word0", got_w(0), exp_w(8'hBC, 1'b1));
        check("s1_word1", got_w(1), exp_w(8'h5A, 1'b0));
        check("s1_word2", got_w(2), exp_w(8'hC3, 1'b0));

        // Odd offset: one leading garbage bit
        do_reset();
        bitq.push_back(1'b1);
        for (int i = 0; i < 4; i++) add_word(8'hBC);
        add_word(8'hA5);
        bitq.push_back(1'b0);
        send_bits();
        idle(12);
        check("s2_locked", 32'(locked_o), 32'd1);
        check("s2_word0", got_w(0), exp_w(8'hBC, 1'b1));
        check("s2_word1", got_w(1), exp_w(8'hA5, 1'b0));

        // Partial lock broken by a non-sync word
        do_reset();
        send_word(8'hBC); send_word(8'hBC); send_word(8'h11); send_word(8'hBC);
        check("s3_not_locked_after_break", 32'(locked_o), 32'd0);
        send_word(8'hBC); send_word(8'hBC);
        check("s3_no_valid_before_lock", 32'(v_seen), 32'd0);
        send_word(8'hBC);
        check("s3_relocked", 32'(locked_o), 32'd1);
        send_word(8'h77);
        idle(12);
        check("s3_word0", got_w(0), exp_w(8'hBC, 1'b1));
        check("s3_word1", got_w(1), exp_w(8'h77, 1'b0));

        // Backpressure, overflow and pop+push on a full buffer
        do_reset();
        send_word(8'hBC); send_word(8'hBC); send_word(8'hBC);
        send_word(8'h01, 4'b0000); send_word(8'h02, 4'b0000); send_word(8'h03, 4'b0000);
        check("s4_no_overflow_yet", 32'(overflow_o), 32'd0);
        send_word(8'h04, 4'b0000);
        check("s4_overflow_set", 32'(overflow_o), 32'd1);
        send_word(8'h05, 4'b0000);
        check("s4_head_held", 32'({v_o, data_o}), 32'({1'b1, 8'h01}));
        check("s4_nothing_popped", 32'(got.size()), 32'd0);
        send_word(8'h06, 4'b1000);
        send_word(8'h07, 4'b1111);
        send_word(8'h08, 4'b1111);
        idle(12);
        check("s4_word0", got_w(0), exp_w(8'h01, 1'b0));
        check("s4_word1", got_w(1), exp_w(8'h02, 1'b0));
        check("s4_word2", got_w(2), exp_w(8'h05, 1'b0));
        check("s4_word3", got_w(3), exp_w(8'h06, 1'b0));
        check("s4_word4", got_w(4), exp_w(8'h07, 1'b0));
        check("s4_overflow_sticky", 32'(overflow_o), 32'd1);

        // Resync while locked with one word buffered
        do_reset();
        send_word(8'hBC); send_word(8'hBC); send_word(8'hBC);
        send_word(8'hBC, 4'b0000); send_word(8'h5A, 4'b0000);
        check("s5_buffered", 32'({v_o, data_o, sync_o}), 32'({1'b1, 8'hBC, 1'b1}));
        send_word(8'h33, 4'b0000, 4'b1000);
        check("s5_after_resync", 32'({v_o, overflow_o, locked_o}), 32'd0);
        send_word(8'hBC); send_word(8'hBC); send_word(8'hBC);
        check("s5_not_relocked_yet", 32'(locked_o), 32'd0);
        send_word(8'h44);
        check("s5_relocked", 32'(locked_o), 32'd1);
        send_word(8'h55);
        idle(12);
        check("s5_word0", got_w(0), exp_w(8'h44, 1'b0));
        check("s5_word1", got_w(1), exp_w(8'h55, 1'b0));

        // Asynchronous reset mid-word while locked, full and overflowed
        do_reset();
        send_word(8'hBC); send_word(8'hBC); send_word(8'hBC);
        send_word(8'h01, 4'b0000); send_word(8'h02, 4'b0000);
        send_word(8'h03, 4'b0000); send_word(8'h04, 4'b0000);
        check("s6_before_reset", 32'({v_o, locked_o, overflow_o}), 32'b111);
        send_pair(1'b1, 1'b0, 1'b0, 1'b0);
        send_pair(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        check("s6_reset_outputs", 32'({data_o, sync_o, v_o, locked_o, overflow_o}), 32'd0);
        got.delete();
        v_seen = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        send_word(8'hBC); send_word(8'hBC); send_word(8'hBC); send_word(8'hBC);
        send_word(8'h66);
        idle(12);
        check("s6_word0", got_w(0), exp_w(8'hBC, 1'b1));
        check("s6_word1", got_w(1), exp_w(8'h66, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
